// File: rtl/clkdiv_pkg.sv
// Shared types and defaults for the clock-enable divider.
// Optional tick counter is enabled by CLKDIV_TICK_COUNT_EN.
package clkdiv_pkg;

    localparam int CLKDIV_WIDTH     = 8;
    localparam int CLKDIV_RESET_DIV = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } clkdiv_state_t;

endpackage

// File: rtl/clkdiv_if.sv
// Control/status bundle between a divider client and the divider.
// tick_count exists only when CLKDIV_TICK_COUNT_EN is defined.
interface clkdiv_if
    import clkdiv_pkg::*;
#(
    parameter int WIDTH = CLKDIV_WIDTH
);
    logic             run;
    logic [WIDTH-1:0] divisor;
    logic             div_load;
    logic             tick;
    logic             clk_out;
    logic [WIDTH-1:0] count;
    logic             busy;
`ifdef CLKDIV_TICK_COUNT_EN
    logic [15:0]      tick_count;

    modport master (
        output run, divisor, div_load,
        input  tick, clk_out, count, busy, tick_count
    );
    modport slave (
        input  run, divisor, div_load,
        output tick, clk_out, count, busy, tick_count
    );
`else
    modport master (
        output run, divisor, div_load,
        input  tick, clk_out, count, busy
    );
    modport slave (
        input  run, divisor, div_load,
        output tick, clk_out, count, busy
    );
`endif
endinterface

// File: rtl/clkdiv_period_counter.sv
// Phase counter with wrap compare and active/pending divisor registers.
// A load coinciding with a start or wrap bypasses straight into active.
module clkdiv_period_counter
    import clkdiv_pkg::*;
#(
    parameter int WIDTH     = CLKDIV_WIDTH,
    parameter int RESET_DIV = CLKDIV_RESET_DIV
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_advance,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_divisor,
    input  logic             i_div_load,
    output logic             o_wrap,
    output logic [WIDTH-1:0] o_count_next,
    output logic [WIDTH-1:0] o_active_next,
    output logic [WIDTH-1:0] o_count
);
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_active;
    logic [WIDTH-1:0] r_pending;
    logic             w_reload;

    assign o_wrap   = i_advance && (r_count == r_active);
    assign w_reload = o_wrap || i_start;
    assign o_count  = r_count;

    always_comb begin
        o_count_next = r_count;
        if (w_reload)
            o_count_next = '0;
        else if (i_advance)
            o_count_next = r_count + 1'b1;
    end

    always_comb begin
        o_active_next = r_active;
        if (w_reload)
            o_active_next = i_div_load ? i_divisor : r_pending;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count   <= '0;
            r_active  <= WIDTH'(RESET_DIV);
            r_pending <= WIDTH'(RESET_DIV);
        end else begin
            r_count  <= o_count_next;
            r_active <= o_active_next;
            if (i_div_load)
                r_pending <= i_divisor;
        end
    end

endmodule

// File: rtl/clock_enable_divider.sv
// Programmable clock-enable divider: registered tick, clk_out and busy.
// Define CLKDIV_TICK_COUNT_EN to add the 16-bit tick_count output.
module clock_enable_divider
    import clkdiv_pkg::*;
#(
    parameter int WIDTH     = CLKDIV_WIDTH,
    parameter int RESET_DIV = CLKDIV_RESET_DIV
) (
    input  logic     clk,
    input  logic     reset,
    clkdiv_if.slave  bus
);
    clkdiv_state_t    r_state;
    logic             r_tick;
    logic             r_clk_out;
    logic             r_busy;
    logic             w_advance;
    logic             w_start;
    logic             w_wrap;
    logic [WIDTH-1:0] w_count_next;
    logic [WIDTH-1:0] w_active_next;
    logic [WIDTH-1:0] w_count;
    logic [WIDTH:0]   w_period;
    logic [WIDTH:0]   w_half;
    logic             w_zero_next;
    logic             w_hi_next;

    assign w_advance = (r_state != ST_IDLE);
    assign w_start   = (r_state == ST_IDLE) && bus.run;

    clkdiv_period_counter #(
        .WIDTH     (WIDTH),
        .RESET_DIV (RESET_DIV)
    ) u_period (
        .clk           (clk),
        .reset         (reset),
        .i_advance     (w_advance),
        .i_start       (w_start),
        .i_divisor     (bus.divisor),
        .i_div_load    (bus.div_load),
        .o_wrap        (w_wrap),
        .o_count_next  (w_count_next),
        .o_active_next (w_active_next),
        .o_count       (w_count)
    );

    // clk_out is high for the first floor((D+1)/2) phases of the period
    assign w_period    = {1'b0, w_active_next} + {{WIDTH{1'b0}}, 1'b1};
    assign w_half      = w_period >> 1;
    assign w_hi_next   = ({1'b0, w_count_next} < w_half);
    assign w_zero_next = (w_count_next == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_tick    <= 1'b0;
            r_clk_out <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_state   <= bus.run ? ST_RUN : ST_IDLE;
                    r_tick    <= bus.run;
                    r_busy    <= bus.run;
                    r_clk_out <= bus.run && w_hi_next;
                end
                ST_RUN, ST_DRAIN: begin
                    if (bus.run) begin
                        r_state   <= ST_RUN;
                        r_tick    <= w_zero_next;
                        r_busy    <= 1'b1;
                        r_clk_out <= w_hi_next;
                    end else if (w_wrap) begin
                        r_state   <= ST_IDLE;
                        r_tick    <= 1'b0;
                        r_busy    <= 1'b0;
                        r_clk_out <= 1'b0;
                    end else begin
                        r_state   <= ST_DRAIN;
                        r_tick    <= 1'b0;
                        r_busy    <= 1'b1;
                        r_clk_out <= w_hi_next;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_tick    <= 1'b0;
                    r_busy    <= 1'b0;
                    r_clk_out <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tick    = r_tick;
    assign bus.clk_out = r_clk_out;
    assign bus.busy    = r_busy;
    assign bus.count   = w_count;

`ifdef CLKDIV_TICK_COUNT_EN
    logic [15:0] r_tick_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_tick_count <= '0;
        else
            r_tick_count <= r_tick_count + 16'(r_tick);
    end

    assign bus.tick_count = r_tick_count;
`endif

endmodule
